cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_adder_if.sv | 27 ++
 rtl/cla_pipe_adder.sv | 148 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder; slave is the adder side, master the requester.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA add/sub, one GROUP-bit slice per stage; latency STAGES cycles, whole pipe stalls while a
// result waits on out_ready. Define CLA_PIPE_SAT_EN to clamp signed overflow in the final stage.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / GROUP;
  localparam int L      = STAGES - 1;

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign c0           = bus.sub | bus.cin;

  // Stage k owns the registers that feed it; operands shrink by one slice per stage while the
  // resolved low result grows, so the last stage sees a full word.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int WK = WIDTH - k * GROUP;

    logic                     vld;
    logic                     ci;
    logic [WK-1:0]            oa;
    logic [WK-1:0]            ob;
    logic [(k+1)*GROUP-1:0]   res;
    logic [GROUP-1:0]         g;
    logic [GROUP-1:0]         p;
    logic [GROUP-1:0]         s;
    logic [GROUP:0]           c;

    if (k == 0) begin : g_head
      assign vld = bus.in_valid;
      assign ci  = c0;
      assign oa  = bus.a;
      assign ob  = b_eff;
      assign res = s;
    end else begin : g_reg
      logic                 vld_q;
      logic                 ci_q;
      logic [WK-1:0]        a_q;
      logic [WK-1:0]        b_q;
      logic [k*GROUP-1:0]   lo_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          ci_q  <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          lo_q  <= '0;
        end else if (adv) begin
          vld_q <= g_stage[k-1].vld;
          ci_q  <= g_stage[k-1].c[GROUP];
          a_q   <= g_stage[k-1].oa[WK+GROUP-1:GROUP];
          b_q   <= g_stage[k-1].ob[WK+GROUP-1:GROUP];
          lo_q  <= g_stage[k-1].res;
        end
      end

      assign vld = vld_q;
      assign ci  = ci_q;
      assign oa  = a_q;
      assign ob  = b_q;
      assign res = {s, lo_q};
    end

    assign g = oa[GROUP-1:0] & ob[GROUP-1:0];
    assign p = oa[GROUP-1:0] ^ ob[GROUP-1:0];

    // Flat lookahead: every carry is a two-level sum of generate/propagate products.
    always_comb begin : p_cla
      logic pp;
      pp   = 1'b0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
        pp = ci;
        for (int j = 0; j <= i; j++) pp = pp & p[j];
        c[i+1] = pp;
        for (int j = 0; j <= i; j++) begin
          pp = g[j];
          for (int m = j + 1; m <= i; m++) pp = pp & p[m];
          c[i+1] = c[i+1] | pp;
        end
      end
    end

    assign s = p ^ c[GROUP-1:0];
  end

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res_fin;
  logic             co;
  logic             ovf_n;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  assign raw   = g_stage[L].res;
  assign co    = g_stage[L].c[GROUP];
  assign ovf_n = co ^ g_stage[L].c[GROUP-1];

`ifdef CLA_PIPE_SAT_EN
  logic a_msb;
  assign a_msb = g_stage[L].oa[GROUP-1];

  always_comb begin
    res_fin = raw;
    if (ovf_n) res_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_fin = raw;
`endif

  // Data only loads with a valid beat so outputs stay put across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= g_stage[L].vld;
      if (g_stage[L].vld) begin
        sum_q  <= res_fin;
        cout_q <= co;
        ovf_q  <= ovf_n;
        zero_q <= (res_fin == '0);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder in 32/8, 8/8 and 16/4 configurations, checked against an arithmetic model.
module tb_cla_pipe_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
  cla_pipe_adder_if #(.WIDTH(8))  bus8 ();
  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain w-bit arithmetic; overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    logic [63:0] mask, be, t;
    logic        sa, sbe, ss;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    be     = sb ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    t      = ({32'd0, a} & mask) + be + (sb ? 64'd1 : {63'd0, ci});
    r.sum  = t[31:0] & mask[31:0];
    r.cout = t[w];
    sa     = a[w-1];
    sbe    = be[w-1];
    ss     = t[w-1];
    r.ovf  = (sa == sbe) && (ss != sa);
`ifdef CLA_PIPE_SAT_EN
    if (r.ovf) r.sum = sa ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
`endif
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
    case (id)
      0: begin bus32.in_valid = v; bus32.a = a;        bus32.b = b;        bus32.cin = ci; bus32.sub = sb; end
      1: begin bus8.in_valid  = v; bus8.a  = a[7:0];   bus8.b  = b[7:0];   bus8.cin  = ci; bus8.sub  = sb; end
      default: begin bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.cin = ci; bus16.sub = sb; end
    endcase
  endtask

  task automatic set_ready(input int id, input logic r);
    case (id)
      0:       bus32.out_ready = r;
      1:       bus8.out_ready  = r;
      default: bus16.out_ready = r;
    endcase
  endtask

  function automatic logic out_v(input int id);
    case (id)
      0:       return bus32.out_valid;
      1:       return bus8.out_valid;
      default: return bus16.out_valid;
    endcase
  endfunction

  function automatic logic in_rdy(input int id);
    case (id)
      0:       return bus32.in_ready;
      1:       return bus8.in_ready;
      default: return bus16.in_ready;
    endcase
  endfunction

  function automatic res_t out_r(input int id);
    case (id)
      0:       return {bus32.sum, bus32.cout, bus32.ovf, bus32.zero};
      1:       return {24'd0, bus8.sum, bus8.cout, bus8.ovf, bus8.zero};
      default: return {16'd0, bus16.sum, bus16.cout, bus16.ovf, bus16.zero};
    endcase
  endfunction

  // One beat into an idle pipe; latency counts edges from the accepting edge to out_valid.
  task automatic directed(input string tag, input int id, input int w, input int lat,
                          input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    res_t e, g;
    int   n;
    e = model(w, a, b, ci, sb);
    @(negedge clk);
    set_ready(id, 1'b1);
    drive(id, 1'b1, a, b, ci, sb);
    #1 check({tag, ".in_ready"}, in_rdy(id), 1'b1);
    @(posedge clk);
    #1 drive(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 1;
    while (!out_v(id) && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    g = out_r(id);
    check({tag, ".lat"}, n, lat);
    check({tag, ".sum"}, g.sum, e.sum);
    check({tag, ".cout"}, g.cout, e.cout);
    check({tag, ".ovf"}, g.ovf, e.ovf);
    check({tag, ".zero"}, g.zero, e.zero);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        q[$];
    res_t        e, last;
    logic [31:0] ra, rb;
    logic        rc, rs, hold;
    int          sent, got_n, cyc;

    for (int id = 0; id < 3; id++) begin
      drive(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_ready(id, 1'b1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.out_valid", out_v(0), 1'b0);
    check("rst.sum", bus32.sum, 32'd0);
    check("rst.cout", bus32.cout, 1'b0);
    check("rst.ovf", bus32.ovf, 1'b0);
    check("rst.zero", bus32.zero, 1'b0);
    check("rst.in_ready", in_rdy(0), 1'b1);
    check("rst.out_valid8", out_v(1), 1'b0);
    check("rst.out_valid16", out_v(2), 1'b0);

    directed("add_ff", 0, 32, 4, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    directed("ripple", 0, 32, 4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_5_7", 0, 32, 4, 32'd5, 32'd7, 1'b0, 1'b1);
    directed("sub_ovf", 0, 32, 4, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

    // Reset with three beats in flight.
    @(negedge clk);
    set_ready(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1 check("midrst.out_valid", out_v(0), 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst.quiet", out_v(0), 1'b0);
    end
    directed("post_rst", 0, 32, 4, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

    // Random stream with toggling backpressure.
    sent  = 0;
    got_n = 0;
    cyc   = 0;
    hold  = 1'b0;
    last  = '0;
    ra = rnd32(); rb = rnd32(); rc = 1'($urandom); rs = 1'($urandom);
    while (got_n < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      set_ready(0, $urandom_range(0, 2) != 0);
      drive(0, sent < 20, ra, rb, rc, rs);
      #1;
      if (hold) begin
        check("stall.valid", out_v(0), 1'b1);
        check("stall.hold", out_r(0), last);
      end
      check("stream.in_ready", in_rdy(0), !out_v(0) || bus32.out_ready);
      if (out_v(0) && bus32.out_ready) begin
        if (q.size() == 0) begin
          check("stream.extra", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("stream.res", out_r(0), e);
          got_n++;
        end
      end
      hold = out_v(0) && !bus32.out_ready;
      last = out_r(0);
      if (sent < 20 && in_rdy(0)) begin
        q.push_back(model(32, ra, rb, rc, rs));
        sent++;
        ra = rnd32(); rb = rnd32(); rc = 1'($urandom); rs = 1'($urandom);
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_ready(0, 1'b1);
    check("stream.count", got_n, 20);
    check("stream.left", q.size(), 0);

    directed("w8.add_ff", 1, 8, 1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    directed("w8.ripple", 1, 8, 1, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
    directed("w16.add_ff", 2, 16, 4, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    directed("w16.ripple", 2, 16, 4, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    directed("w16.sub_ovf", 2, 16, 4, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
